// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a PC through instruction memory, presents
// fetched words on a valid/ready output register, and handles branch redirects and halt.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'd0,
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [7:0]  out_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  pc, pc_n;
    logic        valid_n;
    logic [31:0] inst_n;
    logic [7:0]  opc_n;
    logic [15:0] count_n;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            out_valid   <= valid_n;
            out_inst    <= inst_n;
            out_pc      <= opc_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = out_valid;
        inst_n  = out_inst;
        opc_n   = out_pc;
        count_n = fetch_count;
        capture = !out_valid || out_ready;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                // A redirect discards the presented word and wins over any capture.
                if (branch_taken) begin
                    pc_n    = branch_target;
                    valid_n = 1'b0;
                end else if (capture) begin
                    inst_n  = mem_inst;
                    opc_n   = pc;
                    valid_n = 1'b1;
                    if (fetch_count != '1) count_n = fetch_count + 16'd1;
                    if (mem_inst[31:28] == HALT_OPCODE) state_n = HALT;
                    else                                pc_n    = pc + 8'd1;
                end
            end
            HALT: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = RESET_PC;
                    valid_n = 1'b0;
                end else if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr = pc;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: combinational memory model, scoreboard of
// expected (pc, inst) transfers, and direct checks of state-visible outputs.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  mem_addr;
    logic [31:0] mem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [256];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    fetch_sequencer #(
        .RESET_PC    (8'd0),
        .HALT_OPCODE (4'b1111)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_inst      (mem_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    assign mem_inst = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc);
        sb.push_back('{pc: pc, inst: mem[pc]});
    endtask

    // Inputs change 1 time unit after posedge, so negedge values decide the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc", {24'd0, out_pc}, {24'd0, e.pc});
                check("sb_inst", out_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | i;
        for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0001 + i;

        rst = 1'b1; start = 1'b0; branch_taken = 1'b0; branch_target = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_pc", {24'd0, out_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);

        // Straight-line run at full throughput
        rst = 1'b0; out_ready = 1'b1; start = 1'b1;
        push(8'd0); push(8'd1); push(8'd2);
        tick();
        start = 1'b0;
        check("s1_idle_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s1_valid", {31'd0, out_valid}, 32'd1);
            check("s1_pc", {24'd0, out_pc}, i);
            check("s1_inst", out_inst, 32'h1000_0001 + i);
        end
        check("s1_count", {16'd0, fetch_count}, 32'd4);

        // Reset with a held word and a branch in the same cycle
        rst = 1'b1; branch_taken = 1'b1; branch_target = 8'd77;
        tick();
        rst = 1'b0; branch_taken = 1'b0;
        check("r2_addr", {24'd0, mem_addr}, 32'd0);
        check("r2_valid", {31'd0, out_valid}, 32'd0);
        check("r2_inst", out_inst, 32'd0);
        check("r2_pc", {24'd0, out_pc}, 32'd0);
        check("r2_count", {16'd0, fetch_count}, 32'd0);
        tick();
        tick();
        check("r2_idle_valid", {31'd0, out_valid}, 32'd0);
        check("r2_idle_addr", {24'd0, mem_addr}, 32'd0);
        check("r2_idle_count", {16'd0, fetch_count}, 32'd0);

        // Back-pressure after the first capture; start during RUN is ignored
        out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("bp_cap_pc", {24'd0, out_pc}, 32'd0);
        check("bp_cap_addr", {24'd0, mem_addr}, 32'd1);
        push(8'd0);
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_pc", {24'd0, out_pc}, 32'd0);
            check("bp_hold_inst", out_inst, 32'h1000_0001);
            check("bp_hold_addr", {24'd0, mem_addr}, 32'd1);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_rel_pc", {24'd0, out_pc}, 32'd1);
        check("bp_rel_addr", {24'd0, mem_addr}, 32'd2);

        // Branch while a word is held and not accepted
        out_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'd150;
        tick();
        branch_taken = 1'b0;
        check("br_valid", {31'd0, out_valid}, 32'd0);
        check("br_addr", {24'd0, mem_addr}, 32'd150);
        tick();
        check("br_pc", {24'd0, out_pc}, 32'd150);
        check("br_inst", out_inst, 32'h2000_0096);
        check("br_next_addr", {24'd0, mem_addr}, 32'd151);
        push(8'd150); out_ready = 1'b1;
        tick();
        check("br_seq_pc", {24'd0, out_pc}, 32'd151);

        // Wrap from FF to 00 into a halt instruction
        out_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'hFF;
        mem[0] = 32'hF000_0000;
        tick();
        branch_taken = 1'b0;
        check("wr_addr", {24'd0, mem_addr}, 32'hFF);
        check("wr_valid", {31'd0, out_valid}, 32'd0);
        push(8'hFF); push(8'h00); out_ready = 1'b1;
        tick();
        check("wr_pc_ff", {24'd0, out_pc}, 32'hFF);
        check("wr_wrap_addr", {24'd0, mem_addr}, 32'd0);
        check("wr_not_halted", {31'd0, halted}, 32'd0);
        tick();
        check("hl_pc", {24'd0, out_pc}, 32'd0);
        check("hl_inst", out_inst, 32'hF000_0000);
        check("hl_halted", {31'd0, halted}, 32'd1);
        check("hl_addr", {24'd0, mem_addr}, 32'd0);
        out_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'd55;
        for (int k = 0; k < 2; k++) begin
            tick();
            branch_taken = 1'b0;
            check("hl_hold_valid", {31'd0, out_valid}, 32'd1);
            check("hl_hold_addr", {24'd0, mem_addr}, 32'd0);
            check("hl_hold_halted", {31'd0, halted}, 32'd1);
        end
        check("hl_count", {16'd0, fetch_count}, 32'd6);
        out_ready = 1'b1;
        tick();
        check("hl_acc_valid", {31'd0, out_valid}, 32'd0);
        check("hl_acc_halted", {31'd0, halted}, 32'd1);
        tick();
        check("hl_idle_addr", {24'd0, mem_addr}, 32'd0);
        check("hl_idle_count", {16'd0, fetch_count}, 32'd6);

        // Restart from HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_halted", {31'd0, halted}, 32'd0);
        check("rs_valid", {31'd0, out_valid}, 32'd0);
        check("rs_addr", {24'd0, mem_addr}, 32'd0);
        check("rs_count", {16'd0, fetch_count}, 32'd6);
        check("sb_left", sb.size(), 32'd0);
        tick();
        out_ready = 1'b0;
        check("rs_refetch_pc", {24'd0, out_pc}, 32'd0);
        check("rs_rehalt", {31'd0, halted}, 32'd1);
        check("rs_count2", {16'd0, fetch_count}, 32'd7);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
